// File: rtl/tiled_global_controller.sv
// Tiled GEMM sequencer: LOAD -> COMPUTE per K tile, DRAIN per N tile, one ap_done pulse per job.
// Latency N*(K*(ARRAY_SIZE+M)+LATENCY)+1 cycles from accepted start; stream_stall pauses COMPUTE only.
module tiled_global_controller #(
    parameter int ARRAY_SIZE = 16,
    parameter int LATENCY    = 64,
    parameter int CNT_W      = 32,
    parameter int TILE_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ap_start,
    input  logic [CNT_W-1:0]  cfg_seq_len,
    input  logic [TILE_W-1:0] cfg_num_k_tiles,
    input  logic [TILE_W-1:0] cfg_num_n_tiles,
    input  logic              stream_stall,
    output logic              ap_done,
    output logic              ap_idle,
    output logic [2:0]        current_state_dbg,
    output logic              ctrl_weight_load_en,
    output logic [CNT_W-1:0]  ctrl_weight_row,
    output logic              ctrl_input_stream_en,
    output logic              ctrl_acc_clear,
    output logic              ctrl_drain_en,
    output logic [CNT_W-1:0]  ctrl_row_cnt,
    output logic [TILE_W-1:0] ctrl_k_idx,
    output logic [TILE_W-1:0] ctrl_n_idx
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_WROW_LAST  = CNT_W'(ARRAY_SIZE - 1);
    localparam logic [CNT_W-1:0] LP_DRAIN_LAST = CNT_W'(LATENCY - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_wrow;
    logic [CNT_W-1:0]  r_row_cnt;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [CNT_W-1:0]  r_m;
    logic [TILE_W-1:0] r_k;
    logic [TILE_W-1:0] r_n;
    logic [TILE_W-1:0] r_k_idx;
    logic [TILE_W-1:0] r_n_idx;
    logic              w_stream_en;
    logic              w_zero_cfg;

    assign w_stream_en = (r_state == S_COMPUTE) && !stream_stall;
    assign w_zero_cfg  = (cfg_seq_len == '0) || (cfg_num_k_tiles == '0) || (cfg_num_n_tiles == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wrow      <= '0;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_m         <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_k_idx     <= '0;
            r_n_idx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_m         <= cfg_seq_len;
                        r_k         <= cfg_num_k_tiles;
                        r_n         <= cfg_num_n_tiles;
                        r_k_idx     <= '0;
                        r_n_idx     <= '0;
                        r_wrow      <= '0;
                        r_row_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= w_zero_cfg ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_wrow == LP_WROW_LAST) begin
                        r_wrow    <= '0;
                        r_row_cnt <= '0;
                        r_state   <= S_COMPUTE;
                    end else begin
                        r_wrow <= r_wrow + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    // r_m is nonzero here, so r_m-1 cannot wrap even at the counter maximum
                    if (!stream_stall) begin
                        if (r_row_cnt == r_m - 1'b1) begin
                            r_row_cnt <= '0;
                            if (r_k_idx == r_k - 1'b1) begin
                                r_drain_cnt <= '0;
                                r_state     <= S_DRAIN;
                            end else begin
                                r_k_idx <= r_k_idx + 1'b1;
                                r_state <= S_LOAD;
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == LP_DRAIN_LAST) begin
                        r_drain_cnt <= '0;
                        if (r_n_idx == r_n - 1'b1) begin
                            r_state <= S_DONE;
                        end else begin
                            r_n_idx <= r_n_idx + 1'b1;
                            r_k_idx <= '0;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_k_idx <= '0;
                    r_n_idx <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Everything below decodes registered state; only stream_stall reaches outputs combinationally.
    assign ap_done              = (r_state == S_DONE);
    assign ap_idle              = (r_state == S_IDLE);
    assign current_state_dbg    = r_state;
    assign ctrl_weight_load_en  = (r_state == S_LOAD);
    assign ctrl_weight_row      = r_wrow;
    assign ctrl_input_stream_en = w_stream_en;
    assign ctrl_acc_clear       = w_stream_en && (r_k_idx == '0);
    assign ctrl_drain_en        = (r_state == S_DRAIN);
    assign ctrl_row_cnt         = r_row_cnt;
    assign ctrl_k_idx           = r_k_idx;
    assign ctrl_n_idx           = r_n_idx;

endmodule

// File: tb/tb_tiled_global_controller.sv
// Directed bench for tiled_global_controller with ARRAY_SIZE=4, LATENCY=10.
module tb_tiled_global_controller;
    localparam int AS  = 4;
    localparam int LAT = 10;
    localparam int CW  = 32;
    localparam int TW  = 16;
    localparam int OFF = -100;

    logic          clk = 1'b0;
    logic          rst;
    logic          ap_start;
    logic [CW-1:0] cfg_seq_len;
    logic [TW-1:0] cfg_num_k_tiles;
    logic [TW-1:0] cfg_num_n_tiles;
    logic          stream_stall;
    logic          ap_done;
    logic          ap_idle;
    logic [2:0]    current_state_dbg;
    logic          ctrl_weight_load_en;
    logic [CW-1:0] ctrl_weight_row;
    logic          ctrl_input_stream_en;
    logic          ctrl_acc_clear;
    logic          ctrl_drain_en;
    logic [CW-1:0] ctrl_row_cnt;
    logic [TW-1:0] ctrl_k_idx;
    logic [TW-1:0] ctrl_n_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tiled_global_controller #(
        .ARRAY_SIZE(AS), .LATENCY(LAT), .CNT_W(CW), .TILE_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start),
        .cfg_seq_len(cfg_seq_len), .cfg_num_k_tiles(cfg_num_k_tiles),
        .cfg_num_n_tiles(cfg_num_n_tiles), .stream_stall(stream_stall),
        .ap_done(ap_done), .ap_idle(ap_idle), .current_state_dbg(current_state_dbg),
        .ctrl_weight_load_en(ctrl_weight_load_en), .ctrl_weight_row(ctrl_weight_row),
        .ctrl_input_stream_en(ctrl_input_stream_en), .ctrl_acc_clear(ctrl_acc_clear),
        .ctrl_drain_en(ctrl_drain_en), .ctrl_row_cnt(ctrl_row_cnt),
        .ctrl_k_idx(ctrl_k_idx), .ctrl_n_idx(ctrl_n_idx)
    );

    typedef struct {
        int done_cyc;   int n_done;      int idle_c1;     int idle_after;
        int load_cyc;   int stream_cyc;  int clr_cyc;     int drain_cyc;
        int comp_cyc;   int load_bursts; int drain_bursts; int kseq;
        int first_load; int first_stream; int last_stream; int first_drain;
        int any_en;     int stall_seen;  int hold_ok;
        int rst_idle;   int rst_state;   int rst_en;
    } res_t;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle c is the cycle following edge c; start is sampled at edge 0.
    task automatic run_job(input int m, input int k, input int n,
                           input int stall_after, input int stall_len,
                           input int restart_at, input int cfg_at, input int rst_at,
                           input int budget, output res_t r);
        int streamed = 0;
        int stalled  = 0;
        logic prev_load  = 1'b0;
        logic prev_drain = 1'b0;
        r = '{default: 0};
        r.done_cyc = -1; r.first_load = -1; r.first_stream = -1;
        r.last_stream = -1; r.first_drain = -1; r.idle_after = -1;
        r.rst_idle = -1; r.rst_state = -1; r.rst_en = -1;
        cfg_seq_len = CW'(m); cfg_num_k_tiles = TW'(k); cfg_num_n_tiles = TW'(n);
        stream_stall = 1'b0;
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            ap_start = (c == restart_at);
            if (c == cfg_at) begin
                cfg_seq_len = 32'd5;
                cfg_num_k_tiles = 16'd7;
            end
            rst = (c == rst_at);
            stream_stall = (stall_len > 0) && (streamed == stall_after) && (stalled < stall_len);
            #1;
            if (c == 1) r.idle_c1 = int'(ap_idle);
            if (c == rst_at + 1) begin
                r.rst_idle  = int'(ap_idle);
                r.rst_state = int'(current_state_dbg);
                r.rst_en    = int'(ctrl_weight_load_en | ctrl_input_stream_en |
                                   ctrl_acc_clear | ctrl_drain_en | ap_done);
            end
            if (ap_done) begin
                r.n_done++;
                if (r.done_cyc < 0) r.done_cyc = c;
            end
            if (r.done_cyc >= 0 && c == r.done_cyc + 1) r.idle_after = int'(ap_idle);
            if (ctrl_weight_load_en) begin
                r.load_cyc++;
                if (r.first_load < 0) r.first_load = c;
                if (!prev_load) begin
                    r.load_bursts++;
                    r.kseq = (r.kseq << 4) | int'(ctrl_k_idx);
                end
            end
            if (ctrl_drain_en) begin
                r.drain_cyc++;
                if (r.first_drain < 0) r.first_drain = c;
                if (!prev_drain) r.drain_bursts++;
            end
            if (current_state_dbg == 3'd2) r.comp_cyc++;
            if (stream_stall) begin
                stalled++;
                r.stall_seen++;
                if (ctrl_row_cnt == CW'(stall_after) && !ctrl_input_stream_en &&
                    current_state_dbg == 3'd2) r.hold_ok++;
            end
            if (ctrl_input_stream_en) begin
                streamed++;
                r.stream_cyc++;
                r.last_stream = c;
                if (r.first_stream < 0) r.first_stream = c;
            end
            if (ctrl_acc_clear) r.clr_cyc++;
            r.any_en |= int'(ctrl_weight_load_en | ctrl_input_stream_en |
                             ctrl_acc_clear | ctrl_drain_en);
            prev_load  = ctrl_weight_load_en;
            prev_drain = ctrl_drain_en;
            @(posedge clk); #1;
        end
        ap_start = 1'b0;
        stream_stall = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        res_t r;
        rst = 1'b1; ap_start = 1'b0; stream_stall = 1'b0;
        cfg_seq_len = '0; cfg_num_k_tiles = '0; cfg_num_n_tiles = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_idle",  int'(ap_idle), 1);
        chk("reset_state", int'(current_state_dbg), 0);
        chk("reset_en",    int'({ap_done, ctrl_weight_load_en, ctrl_input_stream_en,
                                 ctrl_acc_clear, ctrl_drain_en}), 0);
        chk("reset_cnt",   int'(ctrl_weight_row | ctrl_row_cnt), 0);
        chk("reset_idx",   int'(ctrl_k_idx | ctrl_n_idx), 0);

        // Basic M=32 K=1 N=1
        run_job(32, 1, 1, 0, 0, OFF, OFF, OFF, 60, r);
        chk("basic_idle_c1",      r.idle_c1, 0);
        chk("basic_first_load",   r.first_load, 1);
        chk("basic_load_cyc",     r.load_cyc, 4);
        chk("basic_first_stream", r.first_stream, 5);
        chk("basic_last_stream",  r.last_stream, 36);
        chk("basic_first_drain",  r.first_drain, 37);
        chk("basic_drain_cyc",    r.drain_cyc, 10);
        chk("basic_done_cyc",     r.done_cyc, 47);
        chk("basic_idle_after",   r.idle_after, 1);
        chk("basic_clr_cyc",      r.clr_cyc, 32);
        chk("basic_n_done",       r.n_done, 1);

        // Tiled M=8 K=3 N=2
        run_job(8, 3, 2, 0, 0, OFF, OFF, OFF, 110, r);
        chk("tiled_load_bursts",  r.load_bursts, 6);
        chk("tiled_load_cyc",     r.load_cyc, 24);
        chk("tiled_drain_bursts", r.drain_bursts, 2);
        chk("tiled_drain_cyc",    r.drain_cyc, 20);
        chk("tiled_clr_cyc",      r.clr_cyc, 16);
        chk("tiled_stream_cyc",   r.stream_cyc, 48);
        chk("tiled_kseq",         r.kseq, 32'h0001_2012);
        chk("tiled_done_cyc",     r.done_cyc, 93);

        // Stall: 5 cycles after the 6th streamed row
        run_job(16, 1, 1, 6, 5, OFF, OFF, OFF, 50, r);
        chk("stall_stream_cyc", r.stream_cyc, 16);
        chk("stall_comp_cyc",   r.comp_cyc, 21);
        chk("stall_hold",       r.hold_ok, 5);
        chk("stall_done_cyc",   r.done_cyc, 36);

        // Zero config; the K=0 case also pulses start while in DONE
        run_job(32, 0, 1, 0, 0, 1, OFF, OFF, 6, r);
        chk("zero_k_done",   r.done_cyc, 1);
        chk("zero_k_en",     r.any_en, 0);
        chk("zero_k_idle",   r.idle_after, 1);
        chk("zero_k_ndone",  r.n_done, 1);
        run_job(0, 1, 1, 0, 0, OFF, OFF, OFF, 6, r);
        chk("zero_m_done",   r.done_cyc, 1);
        chk("zero_m_en",     r.any_en, 0);
        run_job(32, 1, 0, 0, 0, OFF, OFF, OFF, 6, r);
        chk("zero_n_done",   r.done_cyc, 1);
        chk("zero_n_en",     r.any_en, 0);
        chk("zero_n_idle",   r.idle_after, 1);

        // Robustness: restart pulse in COMPUTE plus config change after start
        run_job(32, 2, 1, 0, 0, 10, 12, OFF, 100, r);
        chk("robust_done_cyc",   r.done_cyc, 83);
        chk("robust_n_done",     r.n_done, 1);
        chk("robust_stream_cyc", r.stream_cyc, 64);
        chk("robust_load_cyc",   r.load_cyc, 8);

        // Reset in cycle 20
        run_job(32, 2, 1, 0, 0, OFF, OFF, 20, 60, r);
        chk("rst_idle",   r.rst_idle, 1);
        chk("rst_state",  r.rst_state, 0);
        chk("rst_en",     r.rst_en, 0);
        chk("rst_n_done", r.n_done, 0);

        // Fresh start after reset
        run_job(32, 1, 1, 0, 0, OFF, OFF, OFF, 60, r);
        chk("fresh_done_cyc",   r.done_cyc, 47);
        chk("fresh_stream_cyc", r.stream_cyc, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tiled_global_controller.md
# tiled_global_controller

Top-level sequencer for the systolic GEMM engine; the parametrised successor to the single-pass load/compute/drain controller. Runs one GEMM as a grid of weight tiles: `cfg_num_n_tiles` output-column tiles, each accumulated over `cfg_num_k_tiles` reduction tiles. Drives weight-load, input-stream, accumulator-clear and drain enables, and supports back-pressure on the input stream. Sits between the host register file (ap_* handshake) and the PE array, weight buffer and output drain path.

## Interface
- `ARRAY_SIZE`, default 16: cycles needed to load one weight tile (rows of the PE array).
- `LATENCY`, default 64: drain cycles after the last K tile of an N tile.
- `CNT_W`, default 32: width of the sequence-length and row counters.
- `TILE_W`, default 16: width of the tile-count config and the tile indices.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ap_start`  in  1: start request; sampled only in IDLE.
- `cfg_seq_len`  in  CNT_W: M, the input rows streamed per K tile.
- `cfg_num_k_tiles`  in  TILE_W: K tile count.
- `cfg_num_n_tiles`  in  TILE_W: N tile count.
- `stream_stall`  in  1: input FIFO not ready; pauses COMPUTE.
- `ap_done`  out  1: one-cycle pulse in the DONE state.
- `ap_idle`  out  1: high in IDLE only.
- `current_state_dbg`  out  3: encoded state, IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, DONE=4.
- `ctrl_weight_load_en`  out  1: high throughout LOAD.
- `ctrl_weight_row`  out  CNT_W: row being loaded, 0..ARRAY_SIZE-1.
- `ctrl_input_stream_en`  out  1: high in COMPUTE when `stream_stall`=0.
- `ctrl_acc_clear`  out  1: high with `ctrl_input_stream_en` when k_idx==0, so the first pass overwrites the accumulators.
- `ctrl_drain_en`  out  1: high throughout DRAIN.
- `ctrl_row_cnt`  out  CNT_W: index of the current streamed row.
- `ctrl_k_idx`, `ctrl_n_idx`  out  TILE_W each: current tile indices.

## Operation
- Reset: state=IDLE and all counters and indices are 0. All outputs are 0 except `ap_idle`=1.
- Config is latched on the accepted `ap_start`. Later changes to the config inputs have no effect until the next start.
- IDLE:
  - `ap_start`=1 with all of M, K, N nonzero → LOAD, with k_idx=n_idx=0.
  - `ap_start`=1 with any of M, K, N equal to 0 → DONE directly. No enables assert.
- LOAD: `ctrl_weight_row` counts 0..ARRAY_SIZE-1, one row per cycle. After the row ARRAY_SIZE-1 cycle → COMPUTE with row_cnt=0.
- COMPUTE:
  - When `stream_stall`=0, row_cnt increments. After the row_cnt==M-1 non-stalled cycle, the state leaves COMPUTE.
  - When `stream_stall`=1, row_cnt holds and `ctrl_input_stream_en`=0. The stall may last any number of cycles.
  - Exit if k_idx<K-1: k_idx++, go to LOAD. No drain between K tiles; partial sums stay in the array.
  - Exit if k_idx==K-1: go to DRAIN.
- DRAIN: lasts LATENCY cycles; `stream_stall` is ignored. On exit:
  - if n_idx<N-1: n_idx++, k_idx=0, go to LOAD.
  - otherwise go to DONE.
- DONE: one cycle with `ap_done`=1, then IDLE.
- `ap_start` outside IDLE, including during DONE, is ignored and not queued.
- Reset asserted mid-operation: on the next edge, state is IDLE, all enables are 0 and `ap_idle`=1. No `ap_done` pulse.

## Timing
- `ap_start` sampled at edge 0 → first LOAD cycle is cycle 1. `ap_idle` goes low in cycle 1.
- Without stalls, `ap_done` is high in cycle N·(K·(ARRAY_SIZE+M)+LATENCY)+1, and `ap_idle` returns high the cycle after.
- Each stall cycle adds exactly one cycle to that total.
- Zero config: `ap_done` is high in cycle 1, `ap_idle` high in cycle 2.
- Enables and indices are decoded from registered state and counters. There are no combinational paths from inputs to outputs, except `stream_stall` gating `ctrl_input_stream_en` and `ctrl_acc_clear`.
- `ctrl_k_idx` and `ctrl_n_idx` update on the edge entering the next LOAD and stay stable for the whole tile.
- Counters compare against M-1 using CNT_W arithmetic. M=2^CNT_W-1 must work without wrap.

## Test plan
All scenarios use ARRAY_SIZE=4, LATENCY=10.
- Basic: M=32, K=1, N=1.
  - Load high in cycles 1–4, stream 5–36, drain 37–46, `ap_done` in cycle 47, `ap_idle` in cycle 48.
  - `ctrl_acc_clear` high for 32 cycles.
- Tiled: M=8, K=3, N=2.
  - Load asserts in 6 bursts of 4 cycles; 2 drain bursts of 10 cycles.
  - `ctrl_acc_clear` high for 16 cycles total; `ctrl_k_idx` sequence 0,1,2,0,1,2.
  - `ap_done` in cycle 93.
- Stall: M=16, K=1, N=1, `stream_stall` high for 5 cycles after the 6th streamed row.
  - `ctrl_input_stream_en` high exactly 16 cycles; COMPUTE lasts 21 cycles; `ap_done` in cycle 36.
  - `ctrl_row_cnt` holds at 6 during the stall.
- Zero config: K=0 → `ap_done` in cycle 1 and every enable stays 0.
  - Repeat with M=0 and with N=0; same response.
- Robustness, run with M=32, K=2, N=1:
  - Pulse `ap_start` again during COMPUTE → ignored, single `ap_done`.
  - Change `cfg_seq_len` after start → totals unchanged.
  - Assert `rst` in cycle 20 → IDLE and `ap_idle`=1 at the next edge, no `ap_done`.
  - A fresh start afterwards completes normally.
